// File: rtl/bomb_ctrl_if.sv
// rtl/bomb_ctrl_if.sv - bomb controller signal bundle; BOMB_REMOTE_EN adds detonate
interface bomb_ctrl_if;
  logic       tick;
  logic       place_req;
  logic [9:0] b_x;
  logic [9:0] b_y;
  logic       bomb_active;
  logic [9:0] bomb_x;
  logic [9:0] bomb_y;
  logic       exp_active;
  logic [9:0] exp_x;
  logic [9:0] exp_y;
  logic [7:0] scan_idx;
  logic [9:0] scan_box_x;
  logic [9:0] scan_box_y;
  logic       scan_box_alive;
  logic       box_destroy;
  logic [7:0] box_destroy_idx;
  logic       busy;
`ifdef BOMB_REMOTE_EN
  logic       detonate;
`endif

  modport master (
`ifdef BOMB_REMOTE_EN
    output detonate,
`endif
    output tick, place_req, b_x, b_y, scan_box_x, scan_box_y, scan_box_alive,
    input  bomb_active, bomb_x, bomb_y, exp_active, exp_x, exp_y, scan_idx,
           box_destroy, box_destroy_idx, busy
  );

  modport slave (
`ifdef BOMB_REMOTE_EN
    input  detonate,
`endif
    input  tick, place_req, b_x, b_y, scan_box_x, scan_box_y, scan_box_alive,
    output bomb_active, bomb_x, bomb_y, exp_active, exp_x, exp_y, scan_idx,
           box_destroy, box_destroy_idx, busy
  );
endinterface

// File: rtl/bomb_ctrl.sv
// rtl/bomb_ctrl.sv - single-bomb sequencer: fuse, box scan, explosion, cooldown
// Optional remote detonation input enabled by defining BOMB_REMOTE_EN.
module bomb_ctrl #(
  parameter int NUM_BOXES       = 2,
  parameter int FUSE_FRAMES     = 120,
  parameter int EXPLODE_FRAMES  = 30,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int TILE            = 16,
  parameter int ARM             = 48
) (
  input logic         clk,
  input logic         reset,
  bomb_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_FUSE, S_SCAN, S_EXPLODE, S_COOLDOWN} state_t;

  localparam logic [7:0] FUSE_LAST = 8'(FUSE_FRAMES - 1);
  localparam logic [7:0] EXP_LAST  = 8'(EXPLODE_FRAMES - 1);
  localparam logic [7:0] COOL_LAST = 8'(COOLDOWN_FRAMES - 1);
  localparam logic [7:0] IDX_LAST  = 8'(NUM_BOXES - 1);
  localparam logic signed [11:0] TILE_S = 12'(TILE);
  localparam logic signed [11:0] ARM_S  = 12'(ARM);

  state_t     r_state, w_state_nx;
  logic [7:0] r_cnt, w_cnt_nx;
  logic [9:0] r_bomb_x, r_bomb_y, w_bomb_x_nx, w_bomb_y_nx;
  logic [9:0] r_exp_x, r_exp_y, w_exp_x_nx, w_exp_y_nx;
  logic [7:0] r_scan_idx, w_scan_idx_nx;
  logic       r_destroy, w_destroy_nx;
  logic [7:0] r_destroy_idx, w_destroy_idx_nx;

  logic signed [11:0] w_bx, w_by, w_sx, w_sy;
  logic w_hit_h, w_hit_v, w_hit;
  logic w_unused_lsb;

  assign w_unused_lsb = ^{bus.b_x[3:0], bus.b_y[3:0]};

  // Box vs. the two arms of the cross; signed so arms extending past 0 still compare correctly.
  always_comb begin
    w_bx = $signed({2'b00, r_bomb_x});
    w_by = $signed({2'b00, r_bomb_y});
    w_sx = $signed({2'b00, bus.scan_box_x});
    w_sy = $signed({2'b00, bus.scan_box_y});
    w_hit_h = (w_sx < w_bx + TILE_S + ARM_S) && (w_sx + TILE_S > w_bx - ARM_S) &&
              (w_sy < w_by + TILE_S)         && (w_sy + TILE_S > w_by);
    w_hit_v = (w_sx < w_bx + TILE_S)         && (w_sx + TILE_S > w_bx) &&
              (w_sy < w_by + TILE_S + ARM_S) && (w_sy + TILE_S > w_by - ARM_S);
    w_hit   = bus.scan_box_alive && (w_hit_h || w_hit_v);
  end

  always_comb begin
    w_state_nx       = r_state;
    w_cnt_nx         = r_cnt;
    w_bomb_x_nx      = r_bomb_x;
    w_bomb_y_nx      = r_bomb_y;
    w_exp_x_nx       = r_exp_x;
    w_exp_y_nx       = r_exp_y;
    w_scan_idx_nx    = r_scan_idx;
    w_destroy_nx     = 1'b0;
    w_destroy_idx_nx = r_destroy_idx;
    case (r_state)
      S_IDLE: begin
        if (bus.place_req) begin
          w_bomb_x_nx = {bus.b_x[9:4], 4'b0000};
          w_bomb_y_nx = {bus.b_y[9:4], 4'b0000};
          w_cnt_nx    = 8'd0;
          w_state_nx  = S_FUSE;
        end
      end
      S_FUSE: begin
`ifdef BOMB_REMOTE_EN
        if (bus.detonate) begin
          w_state_nx    = S_SCAN;
          w_scan_idx_nx = 8'd0;
          w_cnt_nx      = 8'd0;
        end else
`endif
        if (bus.tick) begin
          if (r_cnt == FUSE_LAST) begin
            w_state_nx    = S_SCAN;
            w_scan_idx_nx = 8'd0;
            w_cnt_nx      = 8'd0;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      S_SCAN: begin
        w_destroy_nx = w_hit;
        if (w_hit) w_destroy_idx_nx = r_scan_idx;
        if (r_scan_idx == IDX_LAST) begin
          w_state_nx    = S_EXPLODE;
          w_exp_x_nx    = r_bomb_x;
          w_exp_y_nx    = r_bomb_y;
          w_cnt_nx      = 8'd0;
          w_scan_idx_nx = 8'd0;
        end else begin
          w_scan_idx_nx = r_scan_idx + 8'd1;
        end
      end
      S_EXPLODE: begin
        if (bus.tick) begin
          if (r_cnt == EXP_LAST) begin
            w_state_nx = S_COOLDOWN;
            w_cnt_nx   = 8'd0;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      S_COOLDOWN: begin
        if (bus.tick) begin
          if (r_cnt == COOL_LAST) begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = 8'd0;
          end else begin
            w_cnt_nx = r_cnt + 8'd1;
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_bomb_x      <= 10'd0;
      r_bomb_y      <= 10'd0;
      r_exp_x       <= 10'd0;
      r_exp_y       <= 10'd0;
      r_scan_idx    <= 8'd0;
      r_destroy     <= 1'b0;
      r_destroy_idx <= 8'd0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_bomb_x      <= w_bomb_x_nx;
      r_bomb_y      <= w_bomb_y_nx;
      r_exp_x       <= w_exp_x_nx;
      r_exp_y       <= w_exp_y_nx;
      r_scan_idx    <= w_scan_idx_nx;
      r_destroy     <= w_destroy_nx;
      r_destroy_idx <= w_destroy_idx_nx;
    end
  end

  assign bus.bomb_active     = (r_state == S_FUSE);
  assign bus.exp_active      = (r_state == S_EXPLODE);
  assign bus.busy            = (r_state != S_IDLE);
  assign bus.bomb_x          = r_bomb_x;
  assign bus.bomb_y          = r_bomb_y;
  assign bus.exp_x           = r_exp_x;
  assign bus.exp_y           = r_exp_y;
  assign bus.scan_idx        = r_scan_idx;
  assign bus.box_destroy     = r_destroy;
  assign bus.box_destroy_idx = r_destroy_idx;

endmodule

// File: tb/tb_bomb_ctrl.sv
// tb/tb_bomb_ctrl.sv - directed self-checking bench for bomb_ctrl
module tb_bomb_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bomb_ctrl_if bus();
  bomb_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  logic [9:0] tb_box_x [2];
  logic [9:0] tb_box_y [2];
  logic       tb_alive [2];
  assign bus.scan_box_x     = (bus.scan_idx == 8'd1) ? tb_box_x[1] : tb_box_x[0];
  assign bus.scan_box_y     = (bus.scan_idx == 8'd1) ? tb_box_y[1] : tb_box_y[0];
  assign bus.scan_box_alive = (bus.scan_idx == 8'd1) ? tb_alive[1] : tb_alive[0];

  int chk = 0;
  int pass = 0;
  int cyc = 0;
  logic [7:0] d_idx_q [$];
  int         d_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.box_destroy) begin
    d_idx_q.push_back(bus.box_destroy_idx);
    d_cyc_q.push_back(cyc);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick = 1'b1; step(); bus.tick = 1'b0; step();
    end
  endtask

  task automatic one_tick();
    bus.tick = 1'b1; step(); bus.tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.tick = 1'b0; bus.place_req = 1'b0; bus.b_x = '0; bus.b_y = '0;
`ifdef BOMB_REMOTE_EN
    bus.detonate = 1'b0;
`endif
    step(); step(); reset = 1'b0; step();
    d_idx_q.delete(); d_cyc_q.delete();
  endtask

  task automatic place(input logic [9:0] x, input logic [9:0] y);
    bus.b_x = x; bus.b_y = y; bus.place_req = 1'b1; step(); bus.place_req = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    seen = 1'b0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.busy || bus.bomb_active || bus.exp_active || bus.box_destroy) seen = 1'b1;
    end
    chk++; if (seen !== 1'b0) $display("FAIL idle_activity got=%b exp=0", seen); else pass++;
    chk++; if ({bus.bomb_x, bus.bomb_y, bus.exp_x, bus.exp_y} !== 40'd0)
      $display("FAIL reset_coords got=%h exp=0", {bus.bomb_x, bus.bomb_y, bus.exp_x, bus.exp_y}); else pass++;
    chk++; if ({bus.scan_idx, bus.box_destroy_idx} !== 16'd0)
      $display("FAIL reset_idx got=%h exp=0", {bus.scan_idx, bus.box_destroy_idx}); else pass++;
  endtask

  task automatic test_full_sequence();
    int c0;
    do_reset();
    tb_box_x[0] = 10'd160; tb_box_y[0] = 10'd50; tb_alive[0] = 1'b1;
    tb_box_x[1] = 10'd177; tb_box_y[1] = 10'd67; tb_alive[1] = 1'b1;
    place(10'd165, 10'd70);
    chk++; if ({bus.bomb_active, bus.busy} !== 2'b11) $display("FAIL place_active got=%b exp=11", {bus.bomb_active, bus.busy}); else pass++;
    chk++; if (bus.bomb_x !== 10'd160) $display("FAIL place_bomb_x got=%0d exp=160", bus.bomb_x); else pass++;
    chk++; if (bus.bomb_y !== 10'd64) $display("FAIL place_bomb_y got=%0d exp=64", bus.bomb_y); else pass++;
    tick_n(119);
    chk++; if (bus.bomb_active !== 1'b1) $display("FAIL fuse_119 got=%b exp=1", bus.bomb_active); else pass++;
    one_tick();
    chk++; if ({bus.bomb_active, bus.exp_active, bus.busy} !== 3'b001) $display("FAIL scan_entry got=%b exp=001", {bus.bomb_active, bus.exp_active, bus.busy}); else pass++;
    chk++; if (bus.scan_idx !== 8'd0) $display("FAIL scan_idx0 got=%0d exp=0", bus.scan_idx); else pass++;
    step();
    chk++; if ({bus.box_destroy, bus.box_destroy_idx, bus.scan_idx} !== {1'b1, 8'd0, 8'd1})
      $display("FAIL destroy0 got=%b/%0d/%0d exp=1/0/1", bus.box_destroy, bus.box_destroy_idx, bus.scan_idx); else pass++;
    chk++; if (bus.exp_active !== 1'b0) $display("FAIL scan_no_exp got=%b exp=0", bus.exp_active); else pass++;
    step();
    chk++; if ({bus.box_destroy, bus.box_destroy_idx, bus.exp_active} !== {1'b1, 8'd1, 1'b1})
      $display("FAIL destroy1_exp got=%b/%0d/%b exp=1/1/1", bus.box_destroy, bus.box_destroy_idx, bus.exp_active); else pass++;
    chk++; if ({bus.exp_x, bus.exp_y} !== {10'd160, 10'd64}) $display("FAIL exp_xy got=%0d,%0d exp=160,64", bus.exp_x, bus.exp_y); else pass++;
    step();
    chk++; if (bus.box_destroy !== 1'b0) $display("FAIL destroy_end got=%b exp=0", bus.box_destroy); else pass++;
    c0 = (d_cyc_q.size() == 2) ? d_cyc_q[1] - d_cyc_q[0] : -1;
    chk++; if (d_idx_q.size() != 2 || d_idx_q[0] !== 8'd0 || d_idx_q[1] !== 8'd1 || c0 != 1)
      $display("FAIL destroy_seq got=%0d pulses gap=%0d exp=2 pulses gap=1", d_idx_q.size(), c0); else pass++;
    tick_n(29);
    chk++; if (bus.exp_active !== 1'b1) $display("FAIL exp_29 got=%b exp=1", bus.exp_active); else pass++;
    one_tick();
    chk++; if ({bus.exp_active, bus.busy} !== 2'b01) $display("FAIL cooldown_entry got=%b exp=01", {bus.exp_active, bus.busy}); else pass++;
    tick_n(14);
    chk++; if (bus.busy !== 1'b1) $display("FAIL cool_14 got=%b exp=1", bus.busy); else pass++;
    one_tick();
    chk++; if (bus.busy !== 1'b0) $display("FAIL idle_return got=%b exp=0", bus.busy); else pass++;
    chk++; if ({bus.exp_x, bus.exp_y} !== {10'd160, 10'd64}) $display("FAIL exp_hold got=%0d,%0d exp=160,64", bus.exp_x, bus.exp_y); else pass++;
  endtask

  task automatic test_no_hit();
    do_reset();
    tb_box_x[0] = 10'd240; tb_box_y[0] = 10'd64; tb_alive[0] = 1'b1;
    tb_box_x[1] = 10'd160; tb_box_y[1] = 10'd50; tb_alive[1] = 1'b0;
    place(10'd165, 10'd70);
    tick_n(120);
    step(); step();
    chk++; if (d_idx_q.size() != 0) $display("FAIL no_hit got=%0d pulses exp=0", d_idx_q.size()); else pass++;
    chk++; if (bus.exp_active !== 1'b1) $display("FAIL no_hit_exp got=%b exp=1", bus.exp_active); else pass++;
  endtask

  task automatic test_place_held();
    do_reset();
    place(10'd165, 10'd70);
    bus.b_x = 10'd300; bus.b_y = 10'd300; bus.place_req = 1'b1;
    tick_n(60);
    chk++; if ({bus.bomb_x, bus.bomb_y} !== {10'd160, 10'd64}) $display("FAIL held_fuse got=%0d,%0d exp=160,64", bus.bomb_x, bus.bomb_y); else pass++;
    tick_n(60); step(); step();
    tick_n(10);
    chk++; if ({bus.exp_active, bus.exp_x, bus.exp_y} !== {1'b1, 10'd160, 10'd64})
      $display("FAIL held_exp got=%b %0d,%0d exp=1 160,64", bus.exp_active, bus.exp_x, bus.exp_y); else pass++;
    bus.place_req = 1'b0;
  endtask

  task automatic test_tick_place_same();
    do_reset();
    bus.tick = 1'b1;
    place(10'd33, 10'd17);
    bus.tick = 1'b0;
    chk++; if ({bus.bomb_x, bus.bomb_y} !== {10'd32, 10'd16}) $display("FAIL snap got=%0d,%0d exp=32,16", bus.bomb_x, bus.bomb_y); else pass++;
    tick_n(119);
    chk++; if (bus.bomb_active !== 1'b1) $display("FAIL tick_not_counted got=%b exp=1", bus.bomb_active); else pass++;
    one_tick();
    chk++; if (bus.bomb_active !== 1'b0) $display("FAIL fuse_end got=%b exp=0", bus.bomb_active); else pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tb_box_x[0] = 10'd160; tb_box_y[0] = 10'd50; tb_alive[0] = 1'b1;
    tb_box_x[1] = 10'd177; tb_box_y[1] = 10'd67; tb_alive[1] = 1'b1;
    place(10'd165, 10'd70);
    tick_n(120);
    reset = 1'b1; #2;
    chk++; if ({bus.busy, bus.exp_active, bus.box_destroy} !== 3'b000) $display("FAIL reset_scan got=%b exp=000", {bus.busy, bus.exp_active, bus.box_destroy}); else pass++;
    step(); step(); reset = 1'b0; step(); step();
    chk++; if (d_idx_q.size() != 0) $display("FAIL reset_scan_pulse got=%0d exp=0", d_idx_q.size()); else pass++;
    place(10'd165, 10'd70);
    tick_n(120); step(); step();
    d_idx_q.delete();
    reset = 1'b1; #2;
    chk++; if (bus.exp_active !== 1'b0) $display("FAIL reset_exp got=%b exp=0", bus.exp_active); else pass++;
    reset = 1'b0;
  endtask

`ifdef BOMB_REMOTE_EN
  task automatic test_remote();
    do_reset();
    place(10'd165, 10'd70);
    tick_n(5);
    bus.detonate = 1'b1; step(); bus.detonate = 1'b0;
    chk++; if ({bus.bomb_active, bus.busy, bus.scan_idx} !== {2'b01, 8'd0})
      $display("FAIL remote got=%b%b/%0d exp=01/0", bus.bomb_active, bus.busy, bus.scan_idx); else pass++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    bus.tick = 1'b0; bus.place_req = 1'b0; bus.b_x = '0; bus.b_y = '0;
`ifdef BOMB_REMOTE_EN
    bus.detonate = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      tb_box_x[i] = '0; tb_box_y[i] = '0; tb_alive[i] = 1'b0;
    end
    test_reset();
    test_full_sequence();
    test_no_hit();
    test_place_held();
    test_tick_place_same();
    test_reset_mid();
`ifdef BOMB_REMOTE_EN
    test_remote();
`endif
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end
endmodule
